// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register file rd port between the control unit
// (default owner) and a debug access port. Debug is granted when the CPU
// leaves the port idle, or after a bounded wait that forces a two-cycle
// CPU stall. Grant decisions, stall and ack are registered (Moore FSM).
module regfile_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int R_ADDR_WIDTH = 5,
    parameter int MAX_WAIT     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [R_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_stall,
    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [R_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    output logic                    dbg_ack,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic [R_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    output logic                    sram_cs,
    output logic                    sram_we,
    output logic                    sram_oe
);

    // Counter wide enough to hold MAX_WAIT; at least one bit when MAX_WAIT = 0.
    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DBG_ADDR = 2'd1,
        DBG_DATA = 2'd2,
        DBG_ACK  = 2'd3
    } state_t;

    state_t             state_r;
    logic [WCW-1:0]     wait_cnt_r;
    logic               cpu_stall_r;
    logic               dbg_ack_r;
    logic [DATA_WIDTH-1:0] dbg_rdata_r;
    logic               grant_s;

    assign cpu_rdata = sram_rdata;
    assign cpu_stall = cpu_stall_r;
    assign dbg_ack   = dbg_ack_r;
    assign dbg_rdata = dbg_rdata_r;

    // Debug wins in IDLE when the CPU is idle or the wait budget is exhausted.
    always_comb begin
        grant_s = 1'b0;
        if ((state_r == IDLE) && dbg_req && (!cpu_req || (wait_cnt_r == WCW'(MAX_WAIT)))) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Port mux: debug drives the SRAM in DBG_ADDR/DBG_DATA, CPU otherwise.
    always_comb begin
        sram_addr  = cpu_addr;
        sram_wdata = cpu_wdata;
        sram_cs    = cpu_req;
        sram_we    = cpu_req & cpu_we;
        sram_oe    = cpu_req & ~cpu_we;
        case (state_r)
            DBG_ADDR: begin
                sram_addr  = dbg_addr;
                sram_wdata = dbg_wdata;
                sram_cs    = 1'b1;
                sram_we    = dbg_we;
                sram_oe    = ~dbg_we;
            end
            DBG_DATA: begin
                // Keep address and oe so read data stays valid for capture.
                sram_addr  = dbg_addr;
                sram_wdata = dbg_wdata;
                sram_cs    = 1'b1;
                sram_we    = 1'b0;
                sram_oe    = ~dbg_we;
            end
            default: begin
                sram_addr  = cpu_addr;
                sram_wdata = cpu_wdata;
                sram_cs    = cpu_req;
                sram_we    = cpu_req & cpu_we;
                sram_oe    = cpu_req & ~cpu_we;
            end
        endcase
    end

    // Arbitration FSM with registered stall/ack and debug read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cpu_stall_r <= 1'b0;
            dbg_ack_r   <= 1'b0;
            dbg_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r     <= DBG_ADDR;
                        cpu_stall_r <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        cpu_stall_r <= 1'b0;
                    end
                    dbg_ack_r <= 1'b0;
                end
                DBG_ADDR: begin
                    state_r     <= DBG_DATA;
                    cpu_stall_r <= 1'b1;
                    dbg_ack_r   <= 1'b0;
                end
                DBG_DATA: begin
                    state_r     <= DBG_ACK;
                    cpu_stall_r <= 1'b0;
                    dbg_ack_r   <= 1'b1;
                    if (!dbg_we) begin
                        dbg_rdata_r <= sram_rdata;
                    end else begin
                        dbg_rdata_r <= dbg_rdata_r;
                    end
                end
                DBG_ACK: begin
                    // No grant here: the requester drops dbg_req during ack.
                    state_r     <= IDLE;
                    cpu_stall_r <= 1'b0;
                    dbg_ack_r   <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cpu_stall_r <= 1'b0;
                    dbg_ack_r   <= 1'b0;
                end
            endcase
        end
    end

    // Bounded-wait counter: counts CPU-blocked cycles of a pending debug request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WCW{1'b0}};
        end else if (grant_s || !dbg_req) begin
            wait_cnt_r <= {WCW{1'b0}};
        end else if ((state_r == IDLE) && cpu_req && (wait_cnt_r != WCW'(MAX_WAIT))) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a MAX_WAIT=4 instance on a small SRAM
// model and a MAX_WAIT=0 instance with a stubbed read-data bus.
module tb_regfile_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main instance (MAX_WAIT = 4) ----------------
    logic       cpu_req, cpu_we, dbg_req, dbg_we;
    logic [4:0] cpu_addr, dbg_addr, sram_addr;
    logic [7:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, sram_wdata;
    logic [7:0] sram_rdata = 8'h00;
    logic       cpu_stall, dbg_ack, sram_cs, sram_we, sram_oe;

    regfile_arbiter #(.DATA_WIDTH(8), .R_ADDR_WIDTH(5), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe)
    );

    // Register-file model: synchronous write, registered read.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_cs && sram_oe) sram_rdata <= mem[sram_addr];
    end

    // ---------------- second instance (MAX_WAIT = 0) ----------------
    logic       d0_cpu_req, d0_cpu_we, d0_dbg_req, d0_dbg_we;
    logic [4:0] d0_cpu_addr, d0_dbg_addr, d0_sram_addr;
    logic [7:0] d0_cpu_wdata, d0_dbg_wdata, d0_cpu_rdata, d0_dbg_rdata, d0_sram_wdata, d0_sram_rdata;
    logic       d0_cpu_stall, d0_dbg_ack, d0_sram_cs, d0_sram_we, d0_sram_oe;

    regfile_arbiter #(.DATA_WIDTH(8), .R_ADDR_WIDTH(5), .MAX_WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(d0_cpu_req), .cpu_we(d0_cpu_we), .cpu_addr(d0_cpu_addr), .cpu_wdata(d0_cpu_wdata),
        .cpu_rdata(d0_cpu_rdata), .cpu_stall(d0_cpu_stall),
        .dbg_req(d0_dbg_req), .dbg_we(d0_dbg_we), .dbg_addr(d0_dbg_addr), .dbg_wdata(d0_dbg_wdata),
        .dbg_ack(d0_dbg_ack), .dbg_rdata(d0_dbg_rdata),
        .sram_addr(d0_sram_addr), .sram_wdata(d0_sram_wdata), .sram_rdata(d0_sram_rdata),
        .sram_cs(d0_sram_cs), .sram_we(d0_sram_we), .sram_oe(d0_sram_oe)
    );

    typedef struct {
        logic       req;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       exp_cs;
        logic       exp_we;
        logic       exp_oe;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; land 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 5'd3,  8'h55, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 5'd31, 8'hAA, 8'h33, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 5'd17, 8'hFF, 8'h44, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 5'd8,  8'h01, 8'hC3, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 5'd21, 8'h7E, 8'h00, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 8'h00;
        d0_cpu_req = 1'b0; d0_cpu_we = 1'b0; d0_cpu_addr = 5'd0; d0_cpu_wdata = 8'h00;
        d0_dbg_req = 1'b0; d0_dbg_we = 1'b0; d0_dbg_addr = 5'd0; d0_dbg_wdata = 8'h00;
        d0_sram_rdata = 8'h00;
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", 32'(dbg_rdata), 32'd0);
        chk("rst_wait", 32'(dut.wait_cnt_r), 32'd0);
        chk("rst_cs", 32'(sram_cs), 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Preload addr 5 = 0xA7 through the CPU port.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 8'hA7;
        #1;
        chk("cpu_wr_we", 32'(sram_we), 32'd1);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Idle CPU, debug read of addr 5.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        #1;
        chk("t1_stall_c0", 32'(cpu_stall), 32'd0);
        step();
        chk("t1_stall_c1", 32'(cpu_stall), 32'd1);
        chk("t1_addr_c1", 32'(sram_addr), 32'd5);
        chk("t1_oe_c1", 32'(sram_oe), 32'd1);
        chk("t1_ack_c1", 32'(dbg_ack), 32'd0);
        step();
        chk("t1_stall_c2", 32'(cpu_stall), 32'd1);
        chk("t1_ack_c2", 32'(dbg_ack), 32'd0);
        step();
        chk("t1_ack_c3", 32'(dbg_ack), 32'd1);
        chk("t1_rdata", 32'(dbg_rdata), 32'hA7);
        chk("t1_stall_c3", 32'(cpu_stall), 32'd0);
        dbg_req = 1'b0;
        step();
        chk("t1_ack_c4", 32'(dbg_ack), 32'd0);

        // Idle CPU, debug write 0x3C to addr 9, then CPU read of addr 9.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 8'h3C;
        step();
        chk("t2_we_addr", 32'(sram_we), 32'd1);
        chk("t2_addr", 32'(sram_addr), 32'd9);
        chk("t2_wdata", 32'(sram_wdata), 32'h3C);
        step();
        chk("t2_we_data", 32'(sram_we), 32'd0);
        step();
        chk("t2_ack", 32'(dbg_ack), 32'd1);
        chk("t2_rdata_hold", 32'(dbg_rdata), 32'hA7);
        dbg_req = 1'b0; dbg_we = 1'b0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
        step();
        cpu_req = 1'b0;
        chk("t2_cpu_rdata", 32'(cpu_rdata), 32'h3C);

        // Continuous CPU traffic, debug read of addr 5 waits MAX_WAIT cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("t3_wait_%0d", i), 32'(dut.wait_cnt_r), 32'(i));
            chk($sformatf("t3_nostall_%0d", i), 32'(cpu_stall), 32'd0);
        end
        step();
        chk("t3_grant_stall", 32'(cpu_stall), 32'd1);
        chk("t3_wait_clr", 32'(dut.wait_cnt_r), 32'd0);
        chk("t3_grant_addr", 32'(sram_addr), 32'd5);
        step();
        chk("t3_stall2", 32'(cpu_stall), 32'd1);
        step();
        chk("t3_stall_end", 32'(cpu_stall), 32'd0);
        chk("t3_ack", 32'(dbg_ack), 32'd1);
        chk("t3_rdata", 32'(dbg_rdata), 32'hA7);
        dbg_req = 1'b0;
        step();
        chk("t3_idle_stall", 32'(cpu_stall), 32'd0);

        // Debug request withdrawn after two blocked cycles.
        dbg_req = 1'b1; dbg_addr = 5'd9;
        step(); step();
        chk("t5_wait2", 32'(dut.wait_cnt_r), 32'd2);
        dbg_req = 1'b0;
        step();
        chk("t5_wait_clr", 32'(dut.wait_cnt_r), 32'd0);
        chk("t5_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("t5_ack", 32'(dbg_ack), 32'd0);
        chk("t5_stall2", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b0;

        // Reset asserted during DBG_DATA aborts the access.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        step(); step();
        chk("t6_in_data", 32'(cpu_stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_stall", 32'(cpu_stall), 32'd0);
        chk("t6_ack", 32'(dbg_ack), 32'd0);
        chk("t6_rdata", 32'(dbg_rdata), 32'd0);
        chk("t6_cs", 32'(sram_cs), 32'd0);
        dbg_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("t6_ack_after", 32'(dbg_ack), 32'd0);
        chk("t6_stall_after", 32'(cpu_stall), 32'd0);

        // MAX_WAIT = 0, dbg_req low: outputs mirror the CPU inputs.
        for (int i = 0; i < 6; i++) begin
            d0_cpu_req = vecs[i].req; d0_cpu_we = vecs[i].we;
            d0_cpu_addr = vecs[i].addr; d0_cpu_wdata = vecs[i].wdata;
            d0_sram_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_cs", i), 32'(d0_sram_cs), 32'(vecs[i].exp_cs));
            chk($sformatf("v%0d_we", i), 32'(d0_sram_we), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_oe", i), 32'(d0_sram_oe), 32'(vecs[i].exp_oe));
            chk($sformatf("v%0d_addr", i), 32'(d0_sram_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_wdata", i), 32'(d0_sram_wdata), 32'(vecs[i].wdata));
            chk($sformatf("v%0d_rdata", i), 32'(d0_cpu_rdata), 32'(vecs[i].rdata));
            chk($sformatf("v%0d_stall", i), 32'(d0_cpu_stall), 32'd0);
            step();
        end

        // MAX_WAIT = 0 with CPU busy: debug wins on the first edge.
        d0_cpu_req = 1'b1; d0_cpu_we = 1'b0; d0_cpu_addr = 5'd1;
        d0_dbg_req = 1'b1; d0_dbg_we = 1'b0; d0_dbg_addr = 5'd12;
        d0_sram_rdata = 8'h5A;
        step();
        chk("m0_stall1", 32'(d0_cpu_stall), 32'd1);
        chk("m0_addr", 32'(d0_sram_addr), 32'd12);
        step();
        chk("m0_stall2", 32'(d0_cpu_stall), 32'd1);
        step();
        chk("m0_ack", 32'(d0_dbg_ack), 32'd1);
        chk("m0_rdata", 32'(d0_dbg_rdata), 32'h5A);
        d0_dbg_req = 1'b0; d0_cpu_req = 1'b0;
        step();
        chk("m0_ack_end", 32'(d0_dbg_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
